traffic_light_rr: RTL and testbench
===================================

# traffic_light_rr

Parametrised N-approach traffic light controller, the successor to the two-road, fixed-sequence controller in the lab designs. Serves N_DIR approaches round-robin with vehicle sensors and skips approaches that have no demand. Green time is bounded by minimum and maximum limits, and the controller rests on green when no other approach is waiting. Yellow and all-red intervals are parametrised. All timing advances on a `tick` strobe, so a top level can drive the block from a clock-enable divider.

## Interface
- `N_DIR`, default 2: number of approaches, at least 2.
- `YELLOW_CYC`, default 2: length of the yellow interval in ticks, at least 1.
- `ALLRED_CYC`, default 1: length of the all-red interval in ticks, at least 1.
- `MIN_GREEN_CYC`, default 4: minimum green length in ticks, at least 1.
- `MAX_GREEN_CYC`, default 16: maximum green length in ticks when another approach is waiting. Must be at least `MIN_GREEN_CYC`.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `tick`  in  1: timing strobe. Timers and state advance only on edges where `tick` = 1.
- `sensor`  in  N_DIR: bit i = 1 means a vehicle is present at approach i.
- `lights`  out  2*N_DIR: `lights[2i+1:2i]` is the light for approach i. Encoding: green = 2'b00, yellow = 2'b01, red = 2'b10.
- `active_dir`  out  $clog2(N_DIR): index of the approach currently owning the phase.

## Operation
- Registers: `state` (GREEN, YELLOW, ALLRED), `active`, `next_dir`, `timer` (width $clog2(MAX_GREEN_CYC+1)).
- Reset values: state = GREEN, active = 0, next_dir = 0, timer = 0.
  - Consequently approach 0 is green, all other approaches are red, and `active_dir` = 0.
- Outputs are Moore outputs, decoded combinationally from the registers:
  - Approach `active` shows green in GREEN, yellow in YELLOW and red in ALLRED.
  - Every other approach is always red.
- `other_req` = OR of `sensor` with bit `active` masked off.
- GREEN, on a tick:
  - `leave` = (timer ≥ MIN_GREEN_CYC−1) && other_req && (!sensor[active] || timer == MAX_GREEN_CYC−1).
  - If `leave`: go to YELLOW, timer ← 0, next_dir ← the first index after `active`, in wrapping order, whose sensor bit is set.
  - Otherwise: timer ← min(timer+1, MAX_GREEN_CYC−1). The timer saturates and never wraps.
- YELLOW, on a tick: if timer == YELLOW_CYC−1, go to ALLRED with timer ← 0; otherwise timer+1.
- ALLRED, on a tick: if timer == ALLRED_CYC−1, go to GREEN with active ← next_dir and timer ← 0; otherwise timer+1.
- Rest on green: if no other approach has demand (`other_req` = 0), the current approach stays green indefinitely, whatever its own sensor shows.
- `next_dir` is latched on entry to YELLOW. Sensor changes during YELLOW or ALLRED do not redirect the phase change.
  - If the selected approach's sensor drops, it still receives its green of at least MIN_GREEN_CYC.
- Round-robin fairness: an approach with continuous demand waits at most (N_DIR−1) × (MAX_GREEN_CYC + YELLOW_CYC + ALLRED_CYC) ticks.

## Timing
- One state update per clock edge qualified by `tick`. With `tick` = 0, all registers hold.
- Lights change in the cycle following the deciding edge; there is no further latency.
- Phase lengths, with `tick` held at 1:
  - green: MIN_GREEN_CYC to MAX_GREEN_CYC edges, or unbounded while resting;
  - yellow: exactly YELLOW_CYC edges;
  - all-red: exactly ALLRED_CYC edges.
- Sensor and `tick` are sampled synchronously. Synchronising the raw sensors is the top level's job.
- Reset mid-phase: outputs return to the reset values immediately, without waiting for a clock edge. The first tick after reset deassertion counts as green tick 1 for approach 0.

## Structure
- Package `tlc_pkg`:
  - `light_t` (2 bits) and the constants GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10;
  - the `phase_t` enum {GREEN, YELLOW, ALLRED}.
  - Existing two-road designs migrate to this package.
- Sub-module `tlc_rr_next`: combinational round-robin picker. Inputs: `req[N_DIR]` and `cur`; output: `nxt`, the first set bit after `cur`, wrapping. Instantiated once.
- The phase FSM, the timer and the output decode live in `traffic_light_rr`.

## Test plan
Common setup: N_DIR = 3, YELLOW_CYC = 2, ALLRED_CYC = 1, MIN_GREEN_CYC = 4, MAX_GREEN_CYC = 8, `tick` = 1 unless stated otherwise.
- Reset asserted, then released with `sensor` = 3'b000 -> `lights` = 6'b10_10_00 and `active_dir` = 0. Both hold for 30 cycles (rest on green).
- `sensor` = 3'b100 from reset release -> approach 0 is:
  - green for edges 1–4, with the transition to yellow on edge 4;
  - yellow through edge 6, with the transition to all-red on edge 6;
  - all-red through edge 7.
  Approach 2 goes green after edge 7, and approach 1 is skipped.
- `sensor` = 3'b011 held -> approach 0 is green for exactly 8 edges (MAX), then yellow for 2 and all-red for 1, then approach 1 is green. Approach 1 then also runs for 8 edges and hands back to approach 0.
- `tick` high every 3rd cycle, stimulus as in the second scenario -> every phase duration is scaled ×3 in clock cycles, and no state changes occur on non-tick cycles.
- `sensor` switches from 3'b010 to 3'b100 during YELLOW -> approach 1 still receives the next green (`next_dir` was latched).
- `reset` pulsed mid-YELLOW, between clock edges -> `lights` = 6'b10_10_00 and `active_dir` = 0 before the next edge. After release, the sequence restarts from green tick 1.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types for the traffic light controllers: per-approach light
// encoding and the phase enumeration used by the phase FSM.
package tlc_pkg;

  typedef logic [1:0] light_t;

  localparam light_t GREEN  = 2'b00;
  localparam light_t YELLOW = 2'b01;
  localparam light_t RED    = 2'b10;

  // Phase literals carry a PH_ prefix so they do not collide with the
  // light constants above in files that import the whole package.
  typedef enum logic [1:0] {
    PH_GREEN,
    PH_YELLOW,
    PH_ALLRED
  } phase_t;

endpackage

// File: rtl/tlc_rr_next.sv
// Round-robin picker: returns the first requesting index after cur,
// searching in wrapping order. Falls back to cur when nobody else requests.
module tlc_rr_next #(
  parameter int N_DIR = 2,
  parameter int DW    = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] req,
  input  logic [DW-1:0]    cur,
  output logic [DW-1:0]    nxt
);

  // Scan cur+1, cur+2, ... (mod N_DIR) and keep the first hit.
  always_comb begin
    logic found;
    int   idx;
    nxt   = cur;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k < N_DIR; k++) begin
      idx = (int'(cur) + k) % N_DIR;
      if (!found && req[idx]) begin
        nxt   = DW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_rr.sv
// N-approach round-robin traffic light controller. Serves approaches with
// demand in wrapping order, bounds green between a minimum and maximum
// length, rests on green when nobody else waits, and steps all timing on
// the tick strobe.
module traffic_light_rr
  import tlc_pkg::*;
#(
  parameter int N_DIR         = 2,
  parameter int YELLOW_CYC    = 2,
  parameter int ALLRED_CYC    = 1,
  parameter int MIN_GREEN_CYC = 4,
  parameter int MAX_GREEN_CYC = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [N_DIR-1:0]         sensor,
  output logic [2*N_DIR-1:0]       lights,
  output logic [$clog2(N_DIR)-1:0] active_dir
);

  localparam int DW   = $clog2(N_DIR);
  // Timer is sized for the longest interval it ever has to count.
  localparam int TMAX = (MAX_GREEN_CYC > YELLOW_CYC)
                        ? ((MAX_GREEN_CYC > ALLRED_CYC) ? MAX_GREEN_CYC : ALLRED_CYC)
                        : ((YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] GMIN_LAST = TW'(MIN_GREEN_CYC - 1);
  localparam logic [TW-1:0] GMAX_LAST = TW'(MAX_GREEN_CYC - 1);
  localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] RED_LAST  = TW'(ALLRED_CYC - 1);

  phase_t            state;
  logic [DW-1:0]     active;
  logic [DW-1:0]     next_dir;
  logic [TW-1:0]     timer;

  logic [N_DIR-1:0]  others;
  logic              other_req;
  logic              leave;
  logic [DW-1:0]     pick;
  light_t            phase_light;

  // Demand from every approach except the one currently owning the phase.
  always_comb begin
    others         = sensor;
    others[active] = 1'b0;
    other_req      = |others;
    leave          = (timer >= GMIN_LAST) && other_req &&
                     (!sensor[active] || (timer == GMAX_LAST));
  end

  tlc_rr_next #(
    .N_DIR (N_DIR)
  ) u_next (
    .req (sensor),
    .cur (active),
    .nxt (pick)
  );

  // Phase FSM and shared interval timer; everything holds while tick is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PH_GREEN;
      active   <= '0;
      next_dir <= '0;
      timer    <= '0;
    end else if (tick) begin
      case (state)
        PH_GREEN: begin
          if (leave) begin
            state    <= PH_YELLOW;
            timer    <= '0;
            next_dir <= pick;
          end else if (timer != GMAX_LAST) begin
            timer <= timer + 1'b1;
          end
        end
        PH_YELLOW: begin
          if (timer == YEL_LAST) begin
            state <= PH_ALLRED;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PH_ALLRED: begin
          if (timer == RED_LAST) begin
            state  <= PH_GREEN;
            active <= next_dir;
            timer  <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= PH_GREEN;
          timer <= '0;
        end
      endcase
    end
  end

  // Moore decode: the owning approach follows the phase, all others are red.
  always_comb begin
    case (state)
      PH_GREEN:  phase_light = GREEN;
      PH_YELLOW: phase_light = YELLOW;
      default:   phase_light = RED;
    endcase
    lights = '0;
    for (int i = 0; i < N_DIR; i++) begin
      lights[2*i +: 2] = (i == int'(active)) ? phase_light : RED;
    end
    active_dir = active;
  end

endmodule

// File: tb/tb_traffic_light_rr.sv
// Bench for traffic_light_rr: constant vector table, hand-written corner
// sequences and randomized traffic compared against a tick-level model.
module tb_traffic_light_rr;

  localparam int N   = 3;
  localparam int YC  = 2;
  localparam int AC  = 1;
  localparam int MIN = 4;
  localparam int MAX = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b1;
  logic [N-1:0] sensor = '0;
  logic [5:0]   lights;
  logic [1:0]   active_dir;

  int vectors = 0;
  int miscompares = 0;

  traffic_light_rr #(
    .N_DIR         (N),
    .YELLOW_CYC    (YC),
    .ALLRED_CYC    (AC),
    .MIN_GREEN_CYC (MIN),
    .MAX_GREEN_CYC (MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .sensor     (sensor),
    .lights     (lights),
    .active_dir (active_dir)
  );

  always #5 clk = ~clk;

  // Reference model: green owner, count of green ticks so far, and a queue
  // of the light colours still to show before the next green (1=yellow,
  // 2=red).
  bit m_green;
  int m_owner;
  int m_gcnt;
  int m_target;
  int m_seq[$];

  task automatic model_reset();
    m_green  = 1'b1;
    m_owner  = 0;
    m_gcnt   = 0;
    m_target = 0;
    m_seq.delete();
  endtask

  task automatic model_step();
    bit other;
    int d;
    if (!tick) return;
    if (m_green) begin
      other = 1'b0;
      for (int i = 0; i < N; i++)
        if (i != m_owner && sensor[i]) other = 1'b1;
      if (m_gcnt >= MIN - 1 && other && (!sensor[m_owner] || m_gcnt >= MAX - 1)) begin
        m_green = 1'b0;
        m_seq.delete();
        for (int i = 0; i < YC; i++) m_seq.push_back(1);
        for (int i = 0; i < AC; i++) m_seq.push_back(2);
        m_target = m_owner;
        for (int k = N - 1; k >= 1; k--)
          if (sensor[(m_owner + k) % N]) m_target = (m_owner + k) % N;
      end else begin
        m_gcnt++;
      end
    end else begin
      d = m_seq.pop_front();
      if (m_seq.size() == 0) begin
        m_green = 1'b1;
        m_owner = m_target;
        m_gcnt  = 0;
      end
    end
  endtask

  function automatic logic [5:0] model_lights();
    logic [5:0] l;
    logic [1:0] c;
    c = m_green ? 2'b00 : ((m_seq[0] == 1) ? 2'b01 : 2'b10);
    for (int i = 0; i < N; i++) l[2*i +: 2] = (i == m_owner) ? c : 2'b10;
    return l;
  endfunction

  task automatic check(input string name, input logic [5:0] exp_l, input logic [1:0] exp_a);
    vectors++;
    if (lights !== exp_l || active_dir !== exp_a) begin
      miscompares++;
      $display("FAIL %s at %0t: lights=%b active_dir=%0d, expected lights=%b active_dir=%0d",
               name, $time, lights, active_dir, exp_l, exp_a);
    end
  endtask

  task automatic check_model(input string name);
    check(name, model_lights(), 2'(m_owner));
  endtask

  // One clock edge: the model steps on the same edge, outputs are then
  // compared at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [2:0] s);
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b1;
    sensor = s;
    model_reset();
    @(negedge clk);
    check("reset_state", 6'b101000, 2'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] sensor;
    logic       tick;
    logic [5:0] lights;
    logic [1:0] active;
  } vec_t;

  vec_t tbl[12];

  int         ck_edge[8];
  logic [5:0] ck_l[8];
  logic [1:0] ck_a[8];
  int         ci;

  initial begin
    // Skip scenario from reset with only approach 2 waiting, then rest,
    // a tick-less hold and a hand-back towards approach 0.
    tbl[0]  = '{3'b100, 1'b1, 6'b101000, 2'd0};
    tbl[1]  = '{3'b100, 1'b1, 6'b101000, 2'd0};
    tbl[2]  = '{3'b100, 1'b1, 6'b101000, 2'd0};
    tbl[3]  = '{3'b100, 1'b1, 6'b101001, 2'd0};
    tbl[4]  = '{3'b100, 1'b1, 6'b101001, 2'd0};
    tbl[5]  = '{3'b100, 1'b1, 6'b101010, 2'd0};
    tbl[6]  = '{3'b100, 1'b1, 6'b001010, 2'd2};
    tbl[7]  = '{3'b100, 1'b1, 6'b001010, 2'd2};
    tbl[8]  = '{3'b011, 1'b0, 6'b001010, 2'd2};
    tbl[9]  = '{3'b001, 1'b1, 6'b001010, 2'd2};
    tbl[10] = '{3'b001, 1'b1, 6'b001010, 2'd2};
    tbl[11] = '{3'b001, 1'b1, 6'b011010, 2'd2};

    model_reset();

    // Rest on green with no demand at all.
    do_reset(3'b000);
    for (int k = 0; k < 30; k++) begin
      cycle();
      check("rest_green", 6'b101000, 2'd0);
    end

    // Vector table.
    do_reset(3'b100);
    for (int i = 0; i < 12; i++) begin
      sensor = tbl[i].sensor;
      tick   = tbl[i].tick;
      cycle();
      check($sformatf("table[%0d]", i), tbl[i].lights, tbl[i].active);
    end

    // Continuous demand on 0 and 1: both run to MAX and alternate.
    ck_edge = '{7, 8, 10, 11, 18, 19, 21, 22};
    ck_l    = '{6'b101000, 6'b101001, 6'b101010, 6'b100010,
                6'b100010, 6'b100110, 6'b101010, 6'b101000};
    ck_a    = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset(3'b011);
    ci = 0;
    for (int k = 1; k <= 22; k++) begin
      cycle();
      if (ci < 8 && k == ck_edge[ci]) begin
        check($sformatf("max_green_edge%0d", k), ck_l[ci], ck_a[ci]);
        ci++;
      end
    end

    // Tick on every third cycle: all phase lengths scale by three.
    do_reset(3'b100);
    for (int c = 0; c < 30; c++) begin
      tick = ((c % 3) == 2);
      cycle();
      check_model($sformatf("slow_tick_c%0d", c));
      if (c == 10) check("slow_tick_still_green", 6'b101000, 2'd0);
      if (c == 11) check("slow_tick_yellow", 6'b101001, 2'd0);
      if (c == 19) check("slow_tick_allred", 6'b101010, 2'd0);
      if (c == 20) check("slow_tick_green2", 6'b001010, 2'd2);
    end
    tick = 1'b1;

    // Sensor moves from approach 1 to approach 2 during yellow.
    do_reset(3'b010);
    for (int k = 1; k <= 4; k++) cycle();
    check("latch_yellow", 6'b101001, 2'd0);
    sensor = 3'b100;
    for (int k = 5; k <= 7; k++) cycle();
    check("latch_next_dir", 6'b100010, 2'd1);

    // Asynchronous reset in the middle of yellow.
    do_reset(3'b010);
    for (int k = 1; k <= 5; k++) cycle();
    check("pre_async_yellow", 6'b101001, 2'd0);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset", 6'b101000, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) cycle();
    check("restart_green3", 6'b101000, 2'd0);
    cycle();
    check("restart_yellow4", 6'b101001, 2'd0);

    // Randomized traffic against the model.
    do_reset(3'($urandom_range(0, 7)));
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) sensor = 3'($urandom_range(0, 7));
      tick = ($urandom_range(0, 3) != 0);
      cycle();
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
